// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle for the decode stage.
// The slave modport is the decode stage itself; the master modport is its environment.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      op;
    logic [4:0]      op_type;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, op, op_type, rs1, rs2, rd, imm, illegal, out_pc
    );

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, op, op_type, rs1, rs2, rd, imm, illegal, out_pc
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: decodes the incoming word combinationally, then
// stores the decoded fields in a small in-order FIFO whose head drives the outputs.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter bit EN_M  = 1'b1,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {FMT_X, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R} fmt_e;

    typedef struct packed {
        logic [6:0]      op;
        logic [4:0]      op_type;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    fmt_e            fmt;
    logic [4:0]      ty;
    logic [31:0]     imm32;
    logic [31:0]     w;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            accept, pop;

    assign w  = bus.instr;
    assign f3 = w[14:12];
    assign f7 = w[31:25];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Classify the opcode/funct fields into an op_type and an encoding format
    always_comb begin
        fmt = FMT_X;
        ty  = 5'd0;
        case (w[6:0])
            7'b0000011: if (f3 == 3'b010) begin ty = 5'd1; fmt = FMT_I; end
            7'b0100011: if (f3 == 3'b010) begin ty = 5'd2; fmt = FMT_S; end
            7'b1101111: begin ty = 5'd3; fmt = FMT_J; end
            7'b0010011: if (f3 == 3'b000) begin ty = 5'd4; fmt = FMT_I; end
            7'b0110011: begin
                case ({f7, f3})
                    {7'h00, 3'b000}: ty = 5'd5;
                    {7'h20, 3'b000}: ty = 5'd6;
                    {7'h01, 3'b000}: ty = EN_M ? 5'd7 : 5'd0;
                    {7'h01, 3'b001}: ty = EN_M ? 5'd8 : 5'd0;
                    {7'h00, 3'b100}: ty = 5'd9;
                    {7'h00, 3'b111}: ty = 5'd10;
                    {7'h00, 3'b110}: ty = 5'd11;
                    default:         ty = 5'd0;
                endcase
                if (ty != 5'd0) fmt = FMT_R;
            end
            7'b0110111: begin ty = 5'd12; fmt = FMT_U; end
            7'b0010111: begin ty = 5'd13; fmt = FMT_U; end
            7'b1100011: begin
                case (f3)
                    3'b000:  ty = 5'd14;
                    3'b001:  ty = 5'd15;
                    3'b100:  ty = 5'd16;
                    3'b101:  ty = 5'd17;
                    default: ty = 5'd0;
                endcase
                if (ty != 5'd0) fmt = FMT_B;
            end
            default: ;
        endcase
    end

    // Extract register fields and immediate for the selected format; illegal words keep only op/pc
    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.op      = w[6:0];
        dec.pc      = bus.in_pc;
        dec.op_type = ty;
        case (fmt)
            FMT_I: begin
                dec.rs1 = w[19:15];
                dec.rd  = w[11:7];
                imm32   = {{20{w[31]}}, w[31:20]};
            end
            FMT_S: begin
                dec.rs1 = w[19:15];
                dec.rs2 = w[24:20];
                imm32   = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            FMT_B: begin
                dec.rs1 = w[19:15];
                dec.rs2 = w[24:20];
                imm32   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            FMT_U: begin
                dec.rd  = w[11:7];
                imm32   = {w[31:12], 12'b0};
            end
            FMT_J: begin
                dec.rd  = w[11:7];
                imm32   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            FMT_R: begin
                dec.rs1 = w[19:15];
                dec.rs2 = w[24:20];
                dec.rd  = w[11:7];
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    // in_ready looks only at count, so a full buffer must drain a slot before it accepts again
    assign bus.in_ready  = (count < CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign accept        = bus.in_valid & bus.in_ready & ~flush;
    assign pop           = bus.out_valid & bus.out_ready & ~flush;

    // FIFO storage, pointers and occupancy; flush empties the buffer and drops this cycle's traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);
        end
    end

    assign head        = mem[rd_ptr];
    assign bus.op      = head.op;
    assign bus.op_type = head.op_type;
    assign bus.rs1     = head.rs1;
    assign bus.rs2     = head.rs2;
    assign bus.rd      = head.rd;
    assign bus.imm     = head.imm;
    assign bus.illegal = head.illegal;
    assign bus.out_pc  = head.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a scoreboard of expected decodes is filled on every accepted
// input and drained on every popped output; scenario tasks add directed checks.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus1 ();
    decode_stage_if #(.XLEN(32)) bus0 ();

    decode_stage #(.XLEN(32), .EN_M(1'b1), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1)
    );
    decode_stage #(.XLEN(32), .EN_M(1'b0), .DEPTH(2)) dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
    );

    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.instr     = bus1.instr;
    assign bus0.in_pc     = bus1.in_pc;
    assign bus0.out_ready = bus1.out_ready;

    typedef struct {
        logic [4:0]  op_type;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        illegal;
        logic [6:0]  op;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    // Reference decode: find the op_type first, then derive which fields the format carries
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] pc, input bit em);
        exp_t e;
        int   t;
        logic [2:0] fn3;
        logic [6:0] fn7;
        fn3 = x[14:12];
        fn7 = x[31:25];
        t = 0;
        if (x[6:0] == 7'h03 && fn3 == 3'd2) t = 1;
        if (x[6:0] == 7'h23 && fn3 == 3'd2) t = 2;
        if (x[6:0] == 7'h6F) t = 3;
        if (x[6:0] == 7'h13 && fn3 == 3'd0) t = 4;
        if (x[6:0] == 7'h33) begin
            if (fn7 == 7'h00 && fn3 == 3'd0) t = 5;
            if (fn7 == 7'h20 && fn3 == 3'd0) t = 6;
            if (fn7 == 7'h01 && fn3 == 3'd0 && em) t = 7;
            if (fn7 == 7'h01 && fn3 == 3'd1 && em) t = 8;
            if (fn7 == 7'h00 && fn3 == 3'd4) t = 9;
            if (fn7 == 7'h00 && fn3 == 3'd7) t = 10;
            if (fn7 == 7'h00 && fn3 == 3'd6) t = 11;
        end
        if (x[6:0] == 7'h37) t = 12;
        if (x[6:0] == 7'h17) t = 13;
        if (x[6:0] == 7'h63) begin
            if (fn3 == 3'd0) t = 14;
            if (fn3 == 3'd1) t = 15;
            if (fn3 == 3'd4) t = 16;
            if (fn3 == 3'd5) t = 17;
        end
        e.op_type = 5'(t);
        e.op = x[6:0];
        e.pc = pc;
        e.illegal = (t == 0);
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.imm = 0;
        if (t == 1 || t == 4) begin
            e.rs1 = x[19:15]; e.rd = x[11:7];
            e.imm = 32'($signed(x[31:20]));
        end else if (t == 2) begin
            e.rs1 = x[19:15]; e.rs2 = x[24:20];
            e.imm = 32'($signed({x[31:25], x[11:7]}));
        end else if (t == 3) begin
            e.rd = x[11:7];
            e.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
        end else if (t >= 5 && t <= 11) begin
            e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.rd = x[11:7];
        end else if (t == 12 || t == 13) begin
            e.rd = x[11:7];
            e.imm = {x[31:12], 12'h000};
        end else if (t >= 14) begin
            e.rs1 = x[19:15]; e.rs2 = x[24:20];
            e.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] pc);
        bus1.in_valid = v;
        bus1.instr    = x;
        bus1.in_pc    = pc;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0);
        bus1.out_ready = 1'b0;
        #2;
        checks++;
        if ({bus1.in_ready, bus1.out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_hs got rdy/vld=%b required 10", {bus1.in_ready, bus1.out_valid});
        end
        checks++;
        if ({bus1.op, bus1.op_type, bus1.rs1, bus1.rs2, bus1.rd, bus1.imm, bus1.illegal, bus1.out_pc} !== '0) begin
            errors++; $display("FAIL reset_out got imm=%h pc=%h type=%0d required zeros", bus1.imm, bus1.out_pc, bus1.op_type);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        bus1.out_ready = 1'b1;
        drive(1'b1, 32'h00652603, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.out_valid, bus1.op_type, bus1.rd, bus1.rs1, bus1.imm} !== {1'b1, 5'd1, 5'd12, 5'd10, 32'd6}) begin
            errors++; $display("FAIL lw got v=%b t=%0d rd=%0d rs1=%0d imm=%0d required 1 1 12 10 6",
                bus1.out_valid, bus1.op_type, bus1.rd, bus1.rs1, bus1.imm);
        end
        step();
    endtask

    task automatic test_jal_bge();
        bus1.out_ready = 1'b1;
        drive(1'b1, 32'h03C0066F, 32'h104);
        step();
        drive(1'b1, 32'h02B55263, 32'h108);
        checks++;
        if ({bus1.op_type, bus1.rd, bus1.imm} !== {5'd3, 5'd12, 32'd60}) begin
            errors++; $display("FAIL jal got t=%0d rd=%0d imm=%0d required 3 12 60", bus1.op_type, bus1.rd, bus1.imm);
        end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.op_type, bus1.rs1, bus1.rs2, bus1.rd, bus1.imm} !== {5'd17, 5'd10, 5'd11, 5'd0, 32'd36}) begin
            errors++; $display("FAIL bge got t=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d required 17 10 11 0 36",
                bus1.op_type, bus1.rs1, bus1.rs2, bus1.rd, bus1.imm);
        end
        step();
    endtask

    task automatic test_mext();
        bus1.out_ready = 1'b1;
        drive(1'b1, 32'h02B50633, 32'h200);
        step();
        drive(1'b1, 32'h40B50633, 32'h204);
        checks++;
        if (bus1.op_type !== 5'd7) begin
            errors++; $display("FAIL mul_en got t=%0d required 7", bus1.op_type);
        end
        checks++;
        if ({bus0.illegal, bus0.op_type, bus0.rd, bus0.imm, bus0.op, bus0.out_pc} !== {1'b1, 5'd0, 5'd0, 32'd0, 7'h33, 32'h200}) begin
            errors++; $display("FAIL mul_dis got ill=%b t=%0d rd=%0d op=%h pc=%h required 1 0 0 33 200",
                bus0.illegal, bus0.op_type, bus0.rd, bus0.op, bus0.out_pc);
        end
        step();
        drive(1'b1, 32'h00001033, 32'h208);
        checks++;
        if ({bus1.op_type, bus1.illegal} !== {5'd6, 1'b0}) begin
            errors++; $display("FAIL sub got t=%0d ill=%b required 6 0", bus1.op_type, bus1.illegal);
        end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.illegal, bus1.op_type, bus1.rd, bus1.rs1, bus1.rs2} !== {1'b1, 5'd0, 15'd0}) begin
            errors++; $display("FAIL sll_illegal got ill=%b t=%0d required 1 0", bus1.illegal, bus1.op_type);
        end
        step();
    endtask

    task automatic test_stall();
        bus1.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h300);
        step();
        drive(1'b1, 32'h00200113, 32'h304);
        step();
        drive(1'b1, 32'h00300193, 32'h308);
        checks++;
        if (bus1.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_full got in_ready=%b required 0", bus1.in_ready);
        end
        step();
        checks++;
        if (q.size() != 2) begin
            errors++; $display("FAIL stall_count got %0d accepted required 2", q.size());
        end
        drive(1'b0, 32'h0, 32'h0);
        bus1.out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain got out_valid=%b required 0", bus1.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus1.out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'h400);
        step();
        drive(1'b1, 32'h00600313, 32'h404);
        step();
        drive(1'b1, 32'h00700393, 32'h408);
        bus1.out_ready = 1'b1;
        checks++;
        if ({bus1.in_ready, bus1.out_valid} !== 2'b01) begin
            errors++; $display("FAIL full_pop got rdy/vld=%b required 01", {bus1.in_ready, bus1.out_valid});
        end
        step();
        checks++;
        if ({bus1.in_ready, bus1.out_pc} !== {1'b1, 32'h404}) begin
            errors++; $display("FAIL after_pop got rdy=%b pc=%h required 1 404", bus1.in_ready, bus1.out_pc);
        end
        step();
        drive(1'b1, 32'h00800413, 32'h40C);
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_pc} !== {2'b11, 32'h408}) begin
            errors++; $display("FAIL acc_pop1 got rdy/vld=%b pc=%h required 11 408", {bus1.in_ready, bus1.out_valid}, bus1.out_pc);
        end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_pc} !== {2'b11, 32'h40C}) begin
            errors++; $display("FAIL acc_pop2 got rdy/vld=%b pc=%h required 11 40c", {bus1.in_ready, bus1.out_valid}, bus1.out_pc);
        end
        step();
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got out_valid=%b required 0", bus1.out_valid);
        end
    endtask

    task automatic test_flush();
        bus1.out_ready = 1'b0;
        drive(1'b1, 32'h00A00513, 32'h500);
        step();
        drive(1'b1, 32'h00B00593, 32'h504);
        step();
        drive(1'b1, 32'h00C00613, 32'h508);
        flush = 1'b1;
        bus1.out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush got vld/rdy=%b required 01", {bus1.out_valid, bus1.in_ready});
        end
        drive(1'b1, 32'h00D00693, 32'h50C);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.out_valid, bus1.out_pc} !== {1'b1, 32'h50C}) begin
            errors++; $display("FAIL post_flush got vld=%b pc=%h required 1 50c", bus1.out_valid, bus1.out_pc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus1.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00713, 32'h600);
        step();
        drive(1'b1, 32'h800007B7, 32'h604);
        step();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.out_valid, bus1.in_ready, bus1.op_type, bus1.imm, bus1.out_pc, bus1.op} !== {2'b01, 5'd0, 32'd0, 32'd0, 7'd0}) begin
            errors++; $display("FAIL reset_mid got vld/rdy=%b imm=%h pc=%h required 01 0 0",
                {bus1.out_valid, bus1.in_ready}, bus1.imm, bus1.out_pc);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step();
        bus1.out_ready = 1'b1;
        drive(1'b1, 32'hFFF00713, 32'h608);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus1.out_valid, bus1.imm} !== {1'b1, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL after_reset got vld=%b imm=%h required 1 ffffffff", bus1.out_valid, bus1.imm);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] tmpl [17] = '{32'h00002003, 32'h00002023, 32'h0000006F, 32'h00000013,
                                   32'h00000033, 32'h40000033, 32'h02000033, 32'h02001033,
                                   32'h00004033, 32'h00007033, 32'h00006033, 32'h00000037,
                                   32'h00000017, 32'h00000063, 32'h00001063, 32'h00004063,
                                   32'h00005063};
        logic [31:0] x;
        int k;
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 17));
            if (k == 17) x = $urandom();
            else if (tmpl[k][6:0] == 7'h33) x = tmpl[k] | ($urandom() & 32'h01FF8F80);
            else x = tmpl[k] | ($urandom() & 32'hFFFF8F80);
            drive(1'($urandom_range(0, 1)), x, $urandom());
            bus1.out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        bus1.out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (q.size() != 0 || bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL random_drain got %0d pending vld=%b required 0 0", q.size(), bus1.out_valid);
        end
    endtask

    initial begin
        exp_t e;
        drive(1'b0, 32'h0, 32'h0);
        bus1.out_ready = 1'b0;
        fork
            // Scoreboard: record accepts, compare pops, and forget everything on flush or reset
            forever begin
                @(negedge clk);
                if (!rst_n || flush) begin
                    q.delete();
                end else begin
                    if (bus1.out_valid && bus1.out_ready) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++; $display("FAIL sb_extra got pc=%h required no output", bus1.out_pc);
                        end else begin
                            e = q.pop_front();
                            if ({bus1.op_type, bus1.rs1, bus1.rs2, bus1.rd, bus1.imm, bus1.illegal, bus1.op, bus1.out_pc}
                                !== {e.op_type, e.rs1, e.rs2, e.rd, e.imm, e.illegal, e.op, e.pc}) begin
                                errors++;
                                $display("FAIL sb_entry got pc=%h t=%0d rs=%0d/%0d rd=%0d imm=%h ill=%b required pc=%h t=%0d rs=%0d/%0d rd=%0d imm=%h ill=%b",
                                    bus1.out_pc, bus1.op_type, bus1.rs1, bus1.rs2, bus1.rd, bus1.imm, bus1.illegal,
                                    e.pc, e.op_type, e.rs1, e.rs2, e.rd, e.imm, e.illegal);
                            end
                        end
                    end
                    if (bus1.in_valid && bus1.in_ready) q.push_back(model(bus1.instr, bus1.in_pc, 1'b1));
                end
            end
        join_none
        test_reset();
        test_lw();
        test_jal_bge();
        test_mext();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
